ysyx_24100005_lsu: RTL and testbench
====================================

// Module: ysyx_24100005_lsu
// PURPOSE
//  Load/store unit sitting directly downstream of the execute datapath: takes the effective address
//  (rs1+imm adder output), funct3, rs2 data and rd, and runs one data-memory transaction over a
//  req/ack bus with variable latency. Handles byte-lane alignment, write-mask generation and
//  lb/lh/lw/lbu/lhu extraction and extension. Hands the load result to writeback via valid/ready.
// PARAMETERS
//  TIMEOUT  255  max cycles mem_req may wait for mem_ack before aborting with error; 0 = no timeout
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   synchronous reset, active-high
//  in_valid    in   1   request from execute stage
//  in_ready    out  1   LSU can accept (state==IDLE)
//  in_addr     in   32  effective byte address
//  in_wdata    in   32  store data (rs2data), unshifted
//  in_funct3   in   3   RV32I load/store funct3
//  in_is_store in   1   1=store (opcode 0100011), 0=load (opcode 0000011)
//  in_rd       in   5   destination register, passed through
//  mem_req     out  1   bus request, held until mem_ack
//  mem_we      out  1   1=write
//  mem_addr    out  32  word address, {in_addr[31:2],2'b00}
//  mem_wdata   out  32  store data shifted to byte lane
//  mem_wmask   out  4   byte-lane write enables; 4'b0000 for reads
//  mem_ack     in   1   completion; mem_rdata valid same cycle for reads
//  mem_rdata   in   32  aligned read word
//  out_valid   out  1   result to writeback
//  out_ready   in   1   writeback accepts
//  out_rdata   out  32  extended load data; 0 for stores and errors
//  out_rd      out  5   captured in_rd
//  out_err     out  1   misaligned / illegal funct3 / timeout
// BEHAVIOUR
//  - Reset: state IDLE; mem_req=0, mem_we=0, mem_wmask=0, out_valid=0, out_err=0, out_rdata=0,
//    timeout counter=0. in_ready=1 from first cycle after reset.
//  - FSM IDLE->REQ->RESP->IDLE. Accept when in_valid&&in_ready; all inputs captured at that edge.
//  - Legal funct3: load 000,001,010,100,101; store 000,001,010. Alignment: half needs addr[0]=0,
//    word needs addr[1:0]=0. Illegal or misaligned: IDLE->RESP directly, out_err=1, no mem_req.
//  - REQ: mem_req=1 from cycle after accept; mem_addr/we/wdata/wmask stable until ack cycle.
//    mem_ack in REQ -> RESP next edge; mem_req low at that edge. mem_ack outside REQ ignored.
//  - Minimum latency: accept at T, mem_req at T+1, ack at T+1 -> out_valid at T+2.
//  - Store lanes: sb mask=1<<a[1:0], data={4{wdata[7:0]}}; sh mask=a[1]?1100:0011,
//    data={2{wdata[15:0]}}; sw mask=1111.
//  - Load extract: byte=rdata>>(8*a[1:0]), half=rdata>>(16*a[1]); lb/lh sign-extend, lbu/lhu
//    zero-extend, lw passthrough. out_rdata registered at ack edge.
//  - Timeout: counter counts REQ cycles; reaching TIMEOUT with no ack -> drop mem_req, RESP with
//    out_err=1. A late ack after that is ignored.
//  - RESP: out_valid=1 and out_* held stable until out_ready; handshake edge -> IDLE, out_valid=0.
//    New request accepted earliest next cycle (no same-cycle overlap; max one outstanding).
//  - Reset mid-operation: any state -> IDLE at that edge, mem_req dropped, result discarded.
// TESTING
//  1. mem word 0x80FF7F01; lb @0x80000003 -> mem_addr 0x80000000, out_rdata 0xFFFFFF80; lbu -> 0x80;
//     lh @..02 -> 0xFFFF80FF; lhu @..02 -> 0x000080FF; lw @..00 -> 0x80FF7F01.
//  2. sh @0x80000002 wdata 0x1234ABCD -> mem_we=1, mem_wmask 4'b1100, mem_wdata 0xABCDABCD,
//     mem_addr 0x80000000; sb @..01 wdata 0x55 -> mask 4'b0010; out_rdata 0.
//  3. lw @0x80000001 -> no mem_req ever, out_valid next cycle with out_err=1, out_rdata 0.
//  4. mem_ack delayed 5 cycles then out_ready low 3 cycles -> mem_req high exactly 6 cycles,
//     out_valid/out_rdata/out_rd stable 4 cycles, in_ready=0 throughout.
//  5. TIMEOUT=4, no ack -> mem_req high 4 cycles, then out_err=1; later ack ignored.
//  6. rst pulse while in REQ -> next cycle mem_req=0, out_valid=0, in_ready=1; pending ack ignored.

Source files
------------

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: one data-memory transaction at a time over a req/ack bus.
// Aligns store data to byte lanes, builds write masks, extracts and extends load data,
// and hands the result to writeback through a valid/ready handshake.
module ysyx_24100005_lsu #(
  parameter int unsigned TIMEOUT = 255  // 0 disables the request timeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_store,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  alo_q;
  logic        is_store_q;

  logic        mem_req_q, mem_we_q, out_valid_q, out_err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, out_rdata_q;
  logic [3:0]  mem_wmask_q;
  logic [4:0]  out_rd_q;

  logic        req_ok;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        timeout_hit;

  assign in_ready  = (state_q == StIdle);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_rd    = out_rd_q;
  assign out_err   = out_err_q;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

  // Decode legality and alignment of the incoming request, and build store lanes.
  always_comb begin
    req_ok  = 1'b0;
    st_mask = 4'b1111;
    st_data = in_wdata;
    case (in_funct3)
      3'b000:  req_ok = 1'b1;
      3'b001:  req_ok = ~in_addr[0];
      3'b010:  req_ok = (in_addr[1:0] == 2'b00);
      3'b100:  req_ok = ~in_is_store;
      3'b101:  req_ok = ~in_is_store & ~in_addr[0];
      default: req_ok = 1'b0;
    endcase
    case (in_funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << in_addr[1:0];
        st_data = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = in_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{in_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = in_wdata;
      end
    endcase
  end

  // Extract and extend load data from the returned word using the captured offset.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (alo_q)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Control FSM with registered bus and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      funct3_q    <= '0;
      alo_q       <= '0;
      is_store_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_rd_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            out_rd_q   <= in_rd;
            funct3_q   <= in_funct3;
            alo_q      <= in_addr[1:0];
            is_store_q <= in_is_store;
            cnt_q      <= '0;
            if (req_ok) begin
              state_q     <= StReq;
              mem_req_q   <= 1'b1;
              mem_we_q    <= in_is_store;
              mem_addr_q  <= {in_addr[31:2], 2'b00};
              mem_wdata_q <= in_is_store ? st_data : 32'h0;
              mem_wmask_q <= in_is_store ? st_mask : 4'b0000;
            end else begin
              // Illegal or misaligned: report straight away without touching the bus.
              state_q     <= StResp;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_rdata_q <= '0;
            end
          end
        end
        StReq: begin
          if (mem_ack || timeout_hit) begin
            state_q     <= StResp;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
            out_valid_q <= 1'b1;
            out_err_q   <= ~mem_ack;
            out_rdata_q <= (mem_ack && !is_store_q) ? ld_data : 32'h0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StResp: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Self-checking bench for the load/store unit: scoreboarded loads, stores, error paths,
// backpressure, timeout (second instance with a short timeout) and mid-operation reset.
module tb_ysyx_24100005_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_is_store;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;

  logic        t_in_valid, t_in_ready;
  logic        t_mem_req, t_mem_we, t_mem_ack;
  logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;
  logic [3:0]  t_mem_wmask;
  logic        t_out_valid, t_out_ready, t_out_err;
  logic [31:0] t_out_rdata;
  logic [4:0]  t_out_rd;
  logic [31:0] t_in_addr;
  logic [4:0]  t_in_rd;

  ysyx_24100005_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_funct3(in_funct3), .in_is_store(in_is_store), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd), .out_err(out_err)
  );

  ysyx_24100005_lsu #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_addr(t_in_addr),
    .in_wdata(32'h0), .in_funct3(3'b010), .in_is_store(1'b0), .in_rd(t_in_rd),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_wmask(t_mem_wmask), .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_rdata(t_out_rdata),
    .out_rd(t_out_rd), .out_err(t_out_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_word;

  // Observations of the last transaction run through the main instance.
  int          o_req_cycles, o_wait_cycles, o_valid_cycles;
  logic        o_got, o_req_unstable, o_busy_ready, o_idle_after;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_wmask;
  logic        o_we, o_err;
  logic [4:0]  o_rd;

  task automatic run_op(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                        input logic st, input logic [4:0] rd, input int ack_delay,
                        input int ready_delay);
    o_req_cycles = 0; o_wait_cycles = 0; o_valid_cycles = 0;
    o_got = 1'b0; o_req_unstable = 1'b0; o_busy_ready = 1'b0; o_idle_after = 1'b0;
    o_addr = 'x; o_wdata = 'x; o_wmask = 'x; o_we = 1'bx;
    in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_funct3 = f3;
    in_is_store = st; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 400 && !o_got; i++) begin
      o_wait_cycles++;
      if (in_ready) o_busy_ready = 1'b1;
      if (out_valid) begin
        o_got = 1'b1;
      end else begin
        if (mem_req) begin
          if (o_req_cycles == 0) begin
            o_addr = mem_addr; o_wdata = mem_wdata; o_wmask = mem_wmask; o_we = mem_we;
          end else if (o_addr !== mem_addr || o_wdata !== mem_wdata || o_wmask !== mem_wmask ||
                       o_we !== mem_we) begin
            o_req_unstable = 1'b1;
          end
          o_req_cycles++;
          if (o_req_cycles == ack_delay + 1) begin
            mem_ack = 1'b1; mem_rdata = mem_word;
          end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
      end
    end
    if (o_got) begin
      o_rdata = out_rdata; o_rd = out_rd; o_err = out_err;
      for (int i = 0; i <= ready_delay; i++) begin
        if (out_valid && out_rdata === o_rdata && out_rd === o_rd && out_err === o_err)
          o_valid_cycles++;
        if (in_ready) o_busy_ready = 1'b1;
        if (i == ready_delay) out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
      o_idle_after = !out_valid && in_ready && !mem_req;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wmask !== 4'b0000) begin
      failures++;
      $display("FAIL reset_bus: req=%b we=%b wmask=%b required 0 0 0000", mem_req, mem_we,
               mem_wmask);
    end
    checks++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_out: valid=%b err=%b rdata=%h required 0 0 0", out_valid, out_err,
               out_rdata);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [7] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002,
                               32'h80000000, 32'h80000001, 32'h80000000};
    logic [2:0]  f3s   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
    logic [31:0] exps  [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                               32'h80FF7F01, 32'h0000007F, 32'h00007F01};
    mem_word = 32'h80FF7F01;
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{rdata: exps[i], rd: 5'(i + 1), err: 1'b0});
      run_op(addrs[i], 32'hFFFFFFFF, f3s[i], 1'b0, 5'(i + 1), 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (!o_got || o_rdata !== e.rdata || o_rd !== e.rd || o_err !== e.err) begin
        failures++;
        $display("FAIL load_%0d: got=%b rdata=%h rd=%0d err=%b required rdata=%h rd=%0d err=%b",
                 i, o_got, o_rdata, o_rd, o_err, e.rdata, e.rd, e.err);
      end
      checks++;
      if (o_addr !== 32'h80000000 || o_we !== 1'b0 || o_wmask !== 4'b0000) begin
        failures++;
        $display("FAIL load_bus_%0d: addr=%h we=%b wmask=%b required 80000000 0 0000", i, o_addr,
                 o_we, o_wmask);
      end
      checks++;
      if (o_req_cycles != 1 || o_wait_cycles != 2 || !o_idle_after) begin
        failures++;
        $display("FAIL load_latency_%0d: req_cycles=%0d out_at=T+%0d idle_after=%b required 1 2 1",
                 i, o_req_cycles, o_wait_cycles + 0, o_idle_after);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] addrs [3] = '{32'h80000002, 32'h80000001, 32'h80000004};
    logic [31:0] wds   [3] = '{32'h1234ABCD, 32'h00000055, 32'hDEADBEEF};
    logic [2:0]  f3s   [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] eaddr [3] = '{32'h80000000, 32'h80000000, 32'h80000004};
    logic [31:0] edata [3] = '{32'hABCDABCD, 32'h55555555, 32'hDEADBEEF};
    logic [3:0]  emask [3] = '{4'b1100, 4'b0010, 4'b1111};
    mem_word = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{rdata: 32'h0, rd: 5'(10 + i), err: 1'b0});
      run_op(addrs[i], wds[i], f3s[i], 1'b1, 5'(10 + i), 1, 0);
      e = sb_q.pop_front();
      checks++;
      if (o_addr !== eaddr[i] || o_we !== 1'b1 || o_wmask !== emask[i] || o_wdata !== edata[i])
      begin
        failures++;
        $display("FAIL store_bus_%0d: addr=%h we=%b mask=%b data=%h required %h 1 %b %h", i,
                 o_addr, o_we, o_wmask, o_wdata, eaddr[i], emask[i], edata[i]);
      end
      checks++;
      if (!o_got || o_rdata !== e.rdata || o_rd !== e.rd || o_err !== e.err ||
          o_req_cycles != 2 || o_req_unstable) begin
        failures++;
        $display("FAIL store_out_%0d: got=%b rdata=%h rd=%0d err=%b req=%0d unstable=%b required rdata=%h rd=%0d err=0 req=2",
                 i, o_got, o_rdata, o_rd, o_err, o_req_cycles, o_req_unstable, e.rdata, e.rd);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5] = '{32'h80000001, 32'h80000003, 32'h80000001, 32'h80000000,
                               32'h80000000};
    logic [2:0]  f3s   [5] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b100};
    logic        sts   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    mem_word = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{rdata: 32'h0, rd: 5'(20 + i), err: 1'b1});
      run_op(addrs[i], 32'hFFFFFFFF, f3s[i], sts[i], 5'(20 + i), 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (!o_got || o_rdata !== e.rdata || o_rd !== e.rd || o_err !== e.err) begin
        failures++;
        $display("FAIL err_out_%0d: got=%b rdata=%h rd=%0d err=%b required rdata=%h rd=%0d err=1",
                 i, o_got, o_rdata, o_rd, o_err, e.rdata, e.rd);
      end
      checks++;
      if (o_req_cycles != 0 || o_wait_cycles != 1 || !o_idle_after) begin
        failures++;
        $display("FAIL err_timing_%0d: req_cycles=%0d out_at=T+%0d idle_after=%b required 0 1 1",
                 i, o_req_cycles, o_wait_cycles, o_idle_after);
      end
    end
  endtask

  task automatic test_backpressure();
    mem_word = 32'h13579BDF;
    sb_q.push_back('{rdata: 32'h13579BDF, rd: 5'd30, err: 1'b0});
    run_op(32'h80000040, 32'h0, 3'b010, 1'b0, 5'd30, 5, 3);
    e = sb_q.pop_front();
    checks++;
    if (o_req_cycles != 6 || o_req_unstable || o_addr !== 32'h80000040) begin
      failures++;
      $display("FAIL bp_req: cycles=%0d unstable=%b addr=%h required 6 0 80000040", o_req_cycles,
               o_req_unstable, o_addr);
    end
    checks++;
    if (o_valid_cycles != 4 || o_busy_ready || !o_idle_after) begin
      failures++;
      $display("FAIL bp_hold: valid_cycles=%0d in_ready_seen=%b idle_after=%b required 4 0 1",
               o_valid_cycles, o_busy_ready, o_idle_after);
    end
    checks++;
    if (!o_got || o_rdata !== e.rdata || o_rd !== e.rd || o_err !== e.err) begin
      failures++;
      $display("FAIL bp_out: rdata=%h rd=%0d err=%b required %h %0d 0", o_rdata, o_rd, o_err,
               e.rdata, e.rd);
    end
  endtask

  task automatic test_timeout();
    int   cnt;
    logic got;
    cnt = 0; got = 1'b0;
    sb_q.push_back('{rdata: 32'h0, rd: 5'd7, err: 1'b1});
    t_in_valid = 1'b1; t_in_addr = 32'h80000010; t_in_rd = 5'd7;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (t_out_valid) got = 1'b1;
      else begin
        if (t_mem_req) cnt++;
        @(posedge clk); #1;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!got || cnt != 4 || t_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_req: got=%b req_cycles=%0d req_now=%b required 1 4 0", got, cnt,
               t_mem_req);
    end
    checks++;
    if (t_out_err !== e.err || t_out_rdata !== e.rdata || t_out_rd !== e.rd) begin
      failures++;
      $display("FAIL timeout_out: err=%b rdata=%h rd=%0d required %b %h %0d", t_out_err,
               t_out_rdata, t_out_rd, e.err, e.rdata, e.rd);
    end
    t_mem_ack = 1'b1; t_mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    t_mem_ack = 1'b0; t_mem_rdata = 32'h0;
    checks++;
    if (t_out_valid !== 1'b1 || t_out_err !== 1'b1 || t_out_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_late_ack: valid=%b err=%b rdata=%h required 1 1 0", t_out_valid,
               t_out_err, t_out_rdata);
    end
    t_out_ready = 1'b1;
    @(posedge clk); #1;
    t_out_ready = 1'b0;
    t_mem_ack = 1'b1;
    @(posedge clk); #1;
    t_mem_ack = 1'b0;
    checks++;
    if (t_in_ready !== 1'b1 || t_out_valid !== 1'b0 || t_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: in_ready=%b valid=%b req=%b required 1 0 0", t_in_ready,
               t_out_valid, t_mem_req);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_addr = 32'h80000020; in_funct3 = 3'b010; in_is_store = 1'b0;
    in_rd = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: mem_req=%b required 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_post: req=%b valid=%b in_ready=%b required 0 0 1", mem_req,
               out_valid, in_ready);
    end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_ack: valid=%b req=%b required 0 0", out_valid, mem_req);
    end
    // The unit must still work normally afterwards.
    mem_word = 32'h80FF7F01;
    sb_q.push_back('{rdata: 32'h00000001, rd: 5'd11, err: 1'b0});
    run_op(32'h80000000, 32'h0, 3'b100, 1'b0, 5'd11, 2, 0);
    e = sb_q.pop_front();
    checks++;
    if (!o_got || o_rdata !== e.rdata || o_rd !== e.rd || o_err !== e.err) begin
      failures++;
      $display("FAIL rstmid_after: rdata=%h rd=%0d err=%b required %h %0d 0", o_rdata, o_rd,
               o_err, e.rdata, e.rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0; in_is_store = 1'b0;
    in_rd = '0; mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0; mem_word = '0;
    t_in_valid = 1'b0; t_in_addr = '0; t_in_rd = '0; t_mem_ack = 1'b0; t_mem_rdata = '0;
    t_out_ready = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
